// File: rtl/free_list_ctrl.sv
// Dispatch allocation and squash-recovery sequencer for the RAT/RRAT PRN free lists.
// Optional FL_CTRL_PERF_EN adds saturating perf_alloc_stall / perf_squash_cnt outputs.
module free_list_ctrl #(
    parameter int N_WAY          = 2,
    parameter int PRN_W          = 6,
    parameter int CTR_W          = 5,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_WAY-1:0]           dis_valid,
    input  logic [N_WAY-1:0]           dis_has_dest,
    output logic [N_WAY-1:0]           dis_grant,
    output logic [N_WAY*PRN_W-1:0]     dis_prn,
    output logic [N_WAY-1:0]           dis_prn_valid,
    input  logic [CTR_W-1:0]           fl_counter,
    output logic [N_WAY-1:0]           fl_pop_en,
    input  logic [N_WAY*(PRN_W+1)-1:0] fl_pop_packet,
    input  logic [N_WAY-1:0]           ret_valid,
    input  logic [N_WAY*PRN_W-1:0]     ret_old_prn,
    output logic                       ret_ready,
    output logic [N_WAY*(PRN_W+1)-1:0] rat_push,
    output logic [N_WAY*(PRN_W+1)-1:0] rrat_push,
    input  logic                       squash_req,
    output logic                       rat_squash,
    output logic                       busy
`ifdef FL_CTRL_PERF_EN
    ,
    output logic [31:0]                perf_alloc_stall,
    output logic [15:0]                perf_squash_cnt
`endif
);

    localparam int PKT_W  = PRN_W + 1;
    localparam int RC_W   = $clog2(RECOVER_CYCLES + 1);
    localparam int NEED_W = CTR_W + 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES);

    typedef enum logic [1:0] {RUN, SQUASH, RECOVER} state_t;

    state_t                   state, state_next;
    logic [RC_W-1:0]          ctr, ctr_next;
    logic [N_WAY*PKT_W-1:0]   replay, replay_next;
    logic [N_WAY*PKT_W-1:0]   ret_pkt;

    logic [N_WAY-1:0]         grant_raw;
    logic [N_WAY-1:0]         pop_raw;
    logic [N_WAY-1:0]         prnv_raw;
    logic [N_WAY*PRN_W-1:0]   prn_raw;
    logic [NEED_W-1:0]        need;
    logic                     chain;
    int                       taken;

    always_comb begin
        ret_pkt = '0;
        for (int i = 0; i < N_WAY; i++) begin
            ret_pkt[i*PKT_W +: PKT_W] = {ret_valid[i], ret_old_prn[i*PRN_W +: PRN_W]};
        end
    end

    // In-order grant: a slot is accepted only if every earlier slot was and the
    // running count of PRNs needed so far fits in the registered occupancy.
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        need      = '0;
        chain     = 1'b1;
        grant_raw = '0;
        for (int i = 0; i < N_WAY; i++) begin
            need = need + NEED_W'(dis_valid[i] & dis_has_dest[i]);
            if (chain && dis_valid[i] && (need <= {1'b0, fl_counter})) begin
                grant_raw[i] = 1'b1;
            end else begin
                chain = 1'b0;
            end
        end
    end

    // The j-th granted destination slot consumes pop lane j.
    always_comb begin
        taken    = 0;
        pop_raw  = '0;
        prnv_raw = '0;
        prn_raw  = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (grant_raw[i] && dis_has_dest[i]) begin
                for (int p = 0; p < N_WAY; p++) begin
                    if (p == taken) begin
                        pop_raw[p]                  = 1'b1;
                        prn_raw[i*PRN_W +: PRN_W]   = fl_pop_packet[p*PKT_W +: PRN_W];
                        prnv_raw[i]                 = fl_pop_packet[p*PKT_W + PRN_W];
                    end
                end
                taken = taken + 1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        ctr_next      = ctr;
        replay_next   = replay;
        dis_grant     = '0;
        fl_pop_en     = '0;
        dis_prn       = '0;
        dis_prn_valid = '0;
        ret_ready     = 1'b0;
        rat_push      = '0;
        rrat_push     = '0;
        rat_squash    = 1'b0;
        busy          = (state != RUN);

        case (state)
            RUN: begin
                ret_ready = 1'b1;
                rat_push  = ret_pkt;
                rrat_push = ret_pkt;
                if (squash_req) begin
                    state_next = SQUASH;
                end else begin
                    dis_grant     = grant_raw;
                    fl_pop_en     = pop_raw;
                    dis_prn       = prn_raw;
                    dis_prn_valid = prnv_raw;
                end
            end
            // The RAT restore this cycle would wipe retire pushes, so they go to
            // the RRAT now and are replayed into the RAT on the next cycle.
            SQUASH: begin
                rat_squash  = 1'b1;
                ret_ready   = 1'b1;
                rrat_push   = ret_pkt;
                replay_next = ret_pkt;
                ctr_next    = RC_LOAD;
                state_next  = squash_req ? SQUASH : RECOVER;
            end
            RECOVER: begin
                ctr_next = ctr - 1'b1;
                if (ctr == RC_LOAD) begin
                    rat_push    = replay;
                    replay_next = '0;
                end else begin
                    ret_ready = 1'b1;
                    rat_push  = ret_pkt;
                    rrat_push = ret_pkt;
                end
                if (squash_req) begin
                    state_next = SQUASH;
                end else if (ctr == RC_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        if (reset) begin
            dis_grant     = '0;
            fl_pop_en     = '0;
            dis_prn       = '0;
            dis_prn_valid = '0;
            ret_ready     = 1'b0;
            rat_push      = '0;
            rrat_push     = '0;
            rat_squash    = 1'b0;
            busy          = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RUN;
            ctr    <= '0;
            // NOTE: the replay buffer is a handful of flops, not a RAM, so it is
            // cleared on reset to guarantee a stale entry can never be drained.
            replay <= '0;
        end else begin
            state  <= state_next;
            ctr    <= ctr_next;
            replay <= replay_next;
        end
    end

`ifdef FL_CTRL_PERF_EN
    logic [31:0] alloc_stall_cnt;
    logic [15:0] squash_cnt;
    logic        stall_hit;
    logic        prev_granted;

    // A stall is the first ungranted slot being valid: the chain only stops on
    // a valid slot when its cumulative need exceeds the occupancy.
    always_comb begin
        stall_hit    = 1'b0;
        prev_granted = 1'b1;
        for (int i = 0; i < N_WAY; i++) begin
            if (prev_granted && !grant_raw[i] && dis_valid[i]) begin
                stall_hit = 1'b1;
            end
            prev_granted = prev_granted & grant_raw[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alloc_stall_cnt <= '0;
            squash_cnt      <= '0;
        end else begin
            if (state == RUN && !squash_req && stall_hit && alloc_stall_cnt != '1) begin
                alloc_stall_cnt <= alloc_stall_cnt + 1'b1;
            end
            if (state_next == SQUASH && state != SQUASH && squash_cnt != '1) begin
                squash_cnt <= squash_cnt + 1'b1;
            end
        end
    end

    assign perf_alloc_stall = reset ? '0 : alloc_stall_cnt;
    assign perf_squash_cnt  = reset ? '0 : squash_cnt;
`endif

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed scoreboard bench for free_list_ctrl (N_WAY=2, RECOVER_CYCLES=2).
// Expected outputs are queued with each stimulus step and compared at the falling edge.
module tb_free_list_ctrl;

    localparam int N_WAY = 2;
    localparam int PRN_W = 6;
    localparam int CTR_W = 5;
    localparam int RC    = 2;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [N_WAY-1:0]           dis_valid, dis_has_dest, dis_grant, dis_prn_valid;
    logic [N_WAY*PRN_W-1:0]     dis_prn;
    logic [CTR_W-1:0]           fl_counter;
    logic [N_WAY-1:0]           fl_pop_en;
    logic [N_WAY*(PRN_W+1)-1:0] fl_pop_packet;
    logic [N_WAY-1:0]           ret_valid;
    logic [N_WAY*PRN_W-1:0]     ret_old_prn;
    logic                       ret_ready;
    logic [N_WAY*(PRN_W+1)-1:0] rat_push, rrat_push;
    logic                       squash_req, rat_squash, busy;
`ifdef FL_CTRL_PERF_EN
    logic [31:0]                perf_alloc_stall;
    logic [15:0]                perf_squash_cnt;
`endif

    free_list_ctrl #(
        .N_WAY(N_WAY), .PRN_W(PRN_W), .CTR_W(CTR_W), .RECOVER_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset),
        .dis_valid(dis_valid), .dis_has_dest(dis_has_dest),
        .dis_grant(dis_grant), .dis_prn(dis_prn), .dis_prn_valid(dis_prn_valid),
        .fl_counter(fl_counter), .fl_pop_en(fl_pop_en), .fl_pop_packet(fl_pop_packet),
        .ret_valid(ret_valid), .ret_old_prn(ret_old_prn), .ret_ready(ret_ready),
        .rat_push(rat_push), .rrat_push(rrat_push),
        .squash_req(squash_req), .rat_squash(rat_squash), .busy(busy)
`ifdef FL_CTRL_PERF_EN
        ,
        .perf_alloc_stall(perf_alloc_stall), .perf_squash_cnt(perf_squash_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [1:0]  grant;
        logic [1:0]  pop;
        logic [11:0] prn;
        logic [1:0]  prnv;
        logic [13:0] rat;
        logic [13:0] rrat;
        logic        rr;
        logic        sq;
        logic        bsy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pk(input logic v, input int p);
        return {v, 6'(p)};
    endfunction

    function automatic logic [13:0] pp(input logic [6:0] l1, input logic [6:0] l0);
        return {l1, l0};
    endfunction

    function automatic logic [11:0] pr(input int p1, input int p0);
        return {6'(p1), 6'(p0)};
    endfunction

    task automatic expect_out(input string tag, input logic [1:0] g, input logic [1:0] pop,
                              input logic [11:0] prn, input logic [1:0] prnv,
                              input logic [13:0] rat, input logic [13:0] rrat,
                              input logic rr, input logic sq, input logic bsy);
        exp_t e;
        e.tag = tag; e.grant = g; e.pop = pop; e.prn = prn; e.prnv = prnv;
        e.rat = rat; e.rrat = rrat; e.rr = rr; e.sq = sq; e.bsy = bsy;
        sb.push_back(e);
    endtask

    task automatic set_dis(input logic [1:0] v, input logic [1:0] hd, input int ctr);
        dis_valid    = v;
        dis_has_dest = hd;
        fl_counter   = CTR_W'(ctr);
    endtask

    task automatic set_ret(input logic [1:0] v, input int p1, input int p0);
        ret_valid   = v;
        ret_old_prn = pr(p1, p0);
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clock);
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard underflow observed=0 expected=1 entries");
        end else begin
            e = sb.pop_front();
            check({e.tag, ".grant"},  32'(dis_grant),     32'(e.grant));
            check({e.tag, ".pop"},    32'(fl_pop_en),     32'(e.pop));
            check({e.tag, ".prn"},    32'(dis_prn),       32'(e.prn));
            check({e.tag, ".prnv"},   32'(dis_prn_valid), 32'(e.prnv));
            check({e.tag, ".rat"},    32'(rat_push),      32'(e.rat));
            check({e.tag, ".rrat"},   32'(rrat_push),     32'(e.rrat));
            check({e.tag, ".ready"},  32'(ret_ready),     32'(e.rr));
            check({e.tag, ".squash"}, 32'(rat_squash),    32'(e.sq));
            check({e.tag, ".busy"},   32'(busy),          32'(e.bsy));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        fl_pop_packet = pp(pk(1'b1, 11), pk(1'b1, 10));

        // Reset cycle: everything quiet even with active inputs.
        reset = 1'b1; squash_req = 1'b1;
        set_dis(2'b11, 2'b11, 5); set_ret(2'b11, 8, 7);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        reset = 1'b0; squash_req = 1'b0;
        set_dis(2'b11, 2'b11, 5); set_ret(2'b01, 6, 5);
        expect_out("full_grant", 2'b11, 2'b11, pr(11, 10), 2'b11,
                   pp(pk(0, 6), pk(1, 5)), pp(pk(0, 6), pk(1, 5)), 1, 0, 0); cycle();

        set_dis(2'b11, 2'b11, 1); set_ret(2'b00, 0, 0);
        expect_out("short_fl", 2'b01, 2'b01, pr(0, 10), 2'b01, 0, 0, 1, 0, 0); cycle();

        set_dis(2'b11, 2'b10, 1);
        expect_out("nodest_s0", 2'b11, 2'b01, pr(10, 0), 2'b10, 0, 0, 1, 0, 0); cycle();

        set_dis(2'b01, 2'b00, 0);
        expect_out("empty_nodest", 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0); cycle();

        set_dis(2'b01, 2'b01, 0);
        expect_out("empty_dest", 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0); cycle();

        // Squash pulse with retire traffic around it.
        squash_req = 1'b1; set_dis(2'b11, 2'b11, 5); set_ret(2'b11, 31, 30);
        expect_out("sq_req", 0, 0, 0, 0, pp(pk(1, 31), pk(1, 30)),
                   pp(pk(1, 31), pk(1, 30)), 1, 0, 0); cycle();

        squash_req = 1'b0; set_ret(2'b11, 41, 40);
        expect_out("squash", 0, 0, 0, 0, 0, pp(pk(1, 41), pk(1, 40)), 1, 1, 1); cycle();

        set_ret(2'b11, 51, 50);
        expect_out("drain", 0, 0, 0, 0, pp(pk(1, 41), pk(1, 40)), 0, 0, 0, 1); cycle();

        set_ret(2'b01, 0, 52);
        expect_out("recover2", 0, 0, 0, 0, pp(pk(0, 0), pk(1, 52)),
                   pp(pk(0, 0), pk(1, 52)), 1, 0, 1); cycle();

        set_ret(2'b00, 0, 0);
        expect_out("resume", 2'b11, 2'b11, pr(11, 10), 2'b11, 0, 0, 1, 0, 0); cycle();

        // Second squash arriving during the drain cycle.
        squash_req = 1'b1;
        expect_out("sq2_req", 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();

        squash_req = 1'b0; set_ret(2'b11, 21, 20);
        expect_out("sq2", 0, 0, 0, 0, 0, pp(pk(1, 21), pk(1, 20)), 1, 1, 1); cycle();

        squash_req = 1'b1; set_ret(2'b11, 61, 60);
        expect_out("sq2_drain", 0, 0, 0, 0, pp(pk(1, 21), pk(1, 20)), 0, 0, 0, 1); cycle();

        squash_req = 1'b0; set_ret(2'b10, 22, 0);
        expect_out("sq3", 0, 0, 0, 0, 0, pp(pk(1, 22), pk(0, 0)), 1, 1, 1); cycle();

        set_ret(2'b00, 0, 0);
        expect_out("sq3_drain", 0, 0, 0, 0, pp(pk(1, 22), pk(0, 0)), 0, 0, 0, 1); cycle();

        expect_out("sq3_rec2", 0, 0, 0, 0, 0, 0, 1, 0, 1); cycle();

        expect_out("resume2", 2'b11, 2'b11, pr(11, 10), 2'b11, 0, 0, 1, 0, 0); cycle();
`ifdef FL_CTRL_PERF_EN
        check("perf.stall", perf_alloc_stall, 32'd2);
        check("perf.squash", 32'(perf_squash_cnt), 32'd3);
`endif

        // Reset landing in the first RECOVER cycle.
        squash_req = 1'b1;
        expect_out("sq4_req", 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();

        squash_req = 1'b0; set_ret(2'b11, 34, 33);
        expect_out("sq4", 0, 0, 0, 0, 0, pp(pk(1, 34), pk(1, 33)), 1, 1, 1); cycle();

        reset = 1'b1; set_ret(2'b00, 0, 0);
        expect_out("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        reset = 1'b0;
        expect_out("post_reset", 2'b11, 2'b11, pr(11, 10), 2'b11, 0, 0, 1, 0, 0); cycle();
`ifdef FL_CTRL_PERF_EN
        check("perf.stall_rst", perf_alloc_stall, 32'd0);
        check("perf.squash_rst", 32'(perf_squash_cnt), 32'd0);
`endif

        check("sb.leftover", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
